read_num_com_mass: RTL and testbench
====================================

// Module: read_num_com_mass
// PURPOSE
//  Read-back decoder for the on-screen 7-segment digit overlay. Watches the rendered
//  overlay pixel stream plus the raster counters, probes the 7 segment boxes of one
//  digit at origin (x,y) and reconstructs the digit value once per frame. Sits beside
//  the digit renderer; feeds the self-check / debug status path.
// PARAMETERS
//  PIX_LAT        1  clocks from countx/county to matching pix_in (renderer latency)
//  HIT_MIN        3  lit probe pixels (of 4) needed to call a segment ON
//  STABLE_FRAMES  3  consecutive identical valid decodes before stable=1 (>=1)
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   synchronous, active-low reset
//  x            in   11  digit origin column (latched at frame_start)
//  y            in   10  digit origin row (latched at frame_start)
//  countx       in   11  raster column counter
//  county       in   10  raster row counter
//  pix_in       in   1   overlay pixel (renderer check output)
//  frame_start  in   1   1-cycle pulse, first pixel of frame
//  frame_end    in   1   1-cycle pulse, last pixel of frame
//  digit        out  4   decoded value 0..9
//  seg_mask     out  7   measured segments, bit0=seg1 .. bit6=seg7
//  digit_valid  out  1   1-cycle pulse, new decode available
//  glyph_err    out  1   seg_mask not a legal glyph (held until next decode)
//  stable       out  1   same legal digit for STABLE_FRAMES frames
// BEHAVIOUR
//  Reset (reset==0 at clk edge): all outputs 0, state S_IDLE, hit counters 0.
//  Counters delayed PIX_LAT clocks so each pix_in is compared to its own coordinate.
//  Segment geometry (offsets from x,y, inclusive): seg1 L-up [0..3]x[0..23]; seg2 top
//  [0..13]x[0..3]; seg3 R-up [10..13]x[0..23]; seg4 L-lo [0..3]x[20..43]; seg5 R-lo
//  [10..13]x[20..43]; seg6 bottom [0..13]x[40..43]; seg7 mid [0..13]x[20..23].
//  Probe windows (2x2, origin dx,dy; in no other box): s1(1,10) s2(6,1) s3(11,10)
//  s4(1,31) s5(11,31) s6(6,41) s7(6,21). Offset sums 12-bit, no wrap; a probe
//  off-raster never hits.
//  Per-segment 3-bit hit counter, saturating at 7; ON if hits >= HIT_MIN.
//  FSM: S_IDLE --frame_start--> S_ACCUM (latch x,y, clear counters).
//   S_ACCUM: count hits; frame_end -> S_DECODE; frame_start without frame_end ->
//   clear counters, relatch x,y, stay S_ACCUM, no decode (aborted frame).
//   S_DECODE (1 cycle): register seg_mask, digit, glyph_err; digit_valid=1 this
//   cycle (2 clocks after frame_end); -> S_ACCUM if frame_start seen, else S_IDLE.
//  frame_end and frame_start same cycle: that cycle's sample belongs to old frame;
//   decode proceeds; new frame counters cleared, latch x,y, accumulate from S_DECODE.
//  frame_start during S_DECODE: same as above (decode completes, new frame opens).
//  frame_end in S_IDLE: ignored.
//  Decode table (mask bits 7..1): 0=0111111 1=0010100 2=1101110 3=1110110
//   4=1010101 5=1110011 6=1111011 7=0010110 8=1111111 9=1110111.
//   Values >9 render as 8; reader returns 8. Illegal mask: digit=0, glyph_err=1.
//  stable: match counter increments on each legal decode equal to previous digit,
//   resets to 1 on new digit, 0 on glyph_err or aborted frame; stable=1 while
//   count >= STABLE_FRAMES; saturates.
//  Reset mid-frame: immediate return to S_IDLE, no digit_valid.
// STRUCTURE
//  Package draw_num_pkg: segment box offsets, probe offsets, SEG_W=7, FSM state
//   enum, function seg_to_digit(mask)->{err,digit} shared with renderer table.
//  Sub-module num_seg_probe (x7): window compare + saturating hit counter + ON flag.
//  Top: counter delay line, FSM, decode regs, stability counter.
// TESTING
//  Renderer drives mark 0..9 at (100,50), one frame each -> digit=mark, valid pulse
//   2 clk after frame_end, glyph_err=0, seg_mask per table.
//  mark=12 -> digit=8, seg_mask=7'h7F, glyph_err=0.
//  Force only seg2 lit -> seg_mask=7'h02, glyph_err=1, digit=0, stable=0.
//  frame_start mid-frame (no frame_end) -> no valid; next full frame decodes normally.
//  mark=5 for 3 frames -> stable=1 on 3rd valid; mark=6 next -> stable=0.
//  reset low during S_ACCUM -> outputs 0, no valid; 1-pixel shifted pix_in with
//   PIX_LAT=1 mismatch still decodes via HIT_MIN=3 except when >1 probe pixel lost.

Source files
------------

// File: rtl/read_num_com_mass_pkg.sv
// Shared constants for the 7-segment overlay: segment boxes, probe windows,
// FSM states and the mask->digit table used by both renderer and reader.
package read_num_com_mass_pkg;

  localparam int SEG_W = 7;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECODE} state_t;

  // Inclusive box bounds relative to the digit origin; index 0 is seg1.
  typedef struct packed {
    logic [3:0] x0;
    logic [3:0] x1;
    logic [5:0] y0;
    logic [5:0] y1;
  } box_t;

  localparam box_t SEG_BOX [SEG_W] = '{
    '{4'd0,  4'd3,  6'd0,  6'd23},
    '{4'd0,  4'd13, 6'd0,  6'd3 },
    '{4'd10, 4'd13, 6'd0,  6'd23},
    '{4'd0,  4'd3,  6'd20, 6'd43},
    '{4'd10, 4'd13, 6'd20, 6'd43},
    '{4'd0,  4'd13, 6'd40, 6'd43},
    '{4'd0,  4'd13, 6'd20, 6'd23}
  };

  // 2x2 probe windows, each inside exactly one segment box.
  localparam logic [3:0] PROBE_DX [SEG_W] = '{4'd1, 4'd6, 4'd11, 4'd1, 4'd11, 4'd6, 4'd6};
  localparam logic [5:0] PROBE_DY [SEG_W] = '{6'd10, 6'd1, 6'd10, 6'd31, 6'd31, 6'd41, 6'd21};

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } dec_t;

  function automatic dec_t seg_to_digit(input logic [SEG_W-1:0] mask);
    dec_t r;
    r = '{err: 1'b0, digit: 4'd0};
    case (mask)
      7'h3F: r.digit = 4'd0;
      7'h14: r.digit = 4'd1;
      7'h6E: r.digit = 4'd2;
      7'h76: r.digit = 4'd3;
      7'h55: r.digit = 4'd4;
      7'h73: r.digit = 4'd5;
      7'h7B: r.digit = 4'd6;
      7'h16: r.digit = 4'd7;
      7'h7F: r.digit = 4'd8;
      7'h77: r.digit = 4'd9;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/read_num_com_mass_if.sv
// Raster/pixel input bundle and decoded-digit result bundle of the overlay reader.
interface read_num_com_mass_if;
  import read_num_com_mass_pkg::*;

  logic [10:0]      x;
  logic [9:0]       y;
  logic [10:0]      countx;
  logic [9:0]       county;
  logic             pix_in;
  logic             frame_start;
  logic             frame_end;
  logic [3:0]       digit;
  logic [SEG_W-1:0] seg_mask;
  logic             digit_valid;
  logic             glyph_err;
  logic             stable;

  modport master (
    output x, y, countx, county, pix_in, frame_start, frame_end,
    input  digit, seg_mask, digit_valid, glyph_err, stable
  );

  modport slave (
    input  x, y, countx, county, pix_in, frame_start, frame_end,
    output digit, seg_mask, digit_valid, glyph_err, stable
  );

endinterface

// File: rtl/read_num_com_mass_seg_probe.sv
// One segment probe: 2x2 window match against the aligned raster position and a
// saturating hit counter; the segment reads ON once enough window pixels are lit.
module read_num_com_mass_seg_probe #(
  parameter logic [3:0] DX      = 4'd0,
  parameter logic [5:0] DY      = 6'd0,
  parameter int         HIT_MIN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ox,
  input  logic [9:0]  oy,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  input  logic        pix,
  input  logic        en,
  input  logic        clr,
  input  logic        ld,
  output logic        seg_on
);

  logic [11:0] wx, wy, px, py;
  logic        hit;
  logic [2:0]  cnt;

  // 12-bit sums cannot wrap, so a window past the raster edge simply never matches.
  assign wx  = {1'b0, ox} + {8'd0, DX};
  assign wy  = {2'b0, oy} + {6'd0, DY};
  assign px  = {1'b0, cx};
  assign py  = {2'b0, cy};
  assign hit = pix && (px >= wx) && (px <= wx + 12'd1) && (py >= wy) && (py <= wy + 12'd1);

  always_ff @(posedge clk) begin
    if (!reset)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (ld)                       cnt <= {2'b00, hit};
    else if (en && hit && cnt != 3'd7) cnt <= cnt + 3'd1;
  end

  assign seg_on = (cnt >= 3'(HIT_MIN));

endmodule

// File: rtl/read_num_com_mass.sv
// Overlay digit reader: aligns raster counters with the rendered pixel, probes the
// seven segments over a frame and decodes the digit plus a stability flag.
module read_num_com_mass
  import read_num_com_mass_pkg::*;
#(
  parameter int PIX_LAT       = 1,
  parameter int HIT_MIN       = 3,
  parameter int STABLE_FRAMES = 3
) (
  input logic               clk,
  input logic               reset,
  read_num_com_mass_if.slave bus
);

  localparam int             MC_W   = $clog2(STABLE_FRAMES + 1);
  localparam logic [MC_W-1:0] MC_SAT = MC_W'(STABLE_FRAMES);

  logic [10:0]      cx;
  logic [9:0]       cy;
  logic [10:0]      ox;
  logic [9:0]       oy;
  logic [SEG_W-1:0] seg_on;
  state_t           state, state_nxt;
  logic             start_seen;
  logic             latch_en, cnt_clr, cnt_ld, cnt_en, dec_en, abort;
  dec_t             res;
  logic [3:0]       digit_r;
  logic [SEG_W-1:0] mask_r;
  logic             valid_r, err_r;
  logic [MC_W-1:0]  mcnt;

  // Counter delay line so each pix_in is compared with its own coordinate.
  if (PIX_LAT == 0) begin : g_nolat
    assign cx = bus.countx;
    assign cy = bus.county;
  end else begin : g_lat
    logic [PIX_LAT-1:0][10:0] cx_pipe;
    logic [PIX_LAT-1:0][9:0]  cy_pipe;
    always_ff @(posedge clk) begin
      if (!reset) begin
        cx_pipe <= '0;
        cy_pipe <= '0;
      end else begin
        cx_pipe[0] <= bus.countx;
        cy_pipe[0] <= bus.county;
        for (int i = 1; i < PIX_LAT; i++) begin
          cx_pipe[i] <= cx_pipe[i-1];
          cy_pipe[i] <= cy_pipe[i-1];
        end
      end
    end
    assign cx = cx_pipe[PIX_LAT-1];
    assign cy = cy_pipe[PIX_LAT-1];
  end

  for (genvar i = 0; i < SEG_W; i++) begin : g_seg
    read_num_com_mass_seg_probe #(
      .DX(PROBE_DX[i]), .DY(PROBE_DY[i]), .HIT_MIN(HIT_MIN)
    ) u_probe (
      .clk(clk), .reset(reset), .ox(ox), .oy(oy), .cx(cx), .cy(cy),
      .pix(bus.pix_in), .en(cnt_en), .clr(cnt_clr), .ld(cnt_ld), .seg_on(seg_on[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      start_seen <= 1'b0;
      ox         <= '0;
      oy         <= '0;
    end else begin
      state      <= state_nxt;
      start_seen <= (state == S_ACCUM) && bus.frame_start && bus.frame_end;
      if (latch_en) begin
        ox <= bus.x;
        oy <= bus.y;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.frame_start) state_nxt = S_ACCUM;
      S_ACCUM:  if (bus.frame_end)   state_nxt = S_DECODE;
      S_DECODE: state_nxt = (start_seen || bus.frame_start) ? S_ACCUM : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // A start coinciding with the end latches the origin at once; the decode cycle then
  // restarts the counters with that cycle's sample, which belongs to the new frame.
  always_comb begin
    latch_en = 1'b0;
    cnt_clr  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_en   = 1'b0;
    dec_en   = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        latch_en = bus.frame_start;
        cnt_clr  = bus.frame_start;
      end
      S_ACCUM: begin
        cnt_en   = 1'b1;
        latch_en = bus.frame_start;
        cnt_clr  = bus.frame_start && !bus.frame_end;
        abort    = bus.frame_start && !bus.frame_end;
      end
      S_DECODE: begin
        dec_en   = 1'b1;
        cnt_ld   = start_seen;
        latch_en = bus.frame_start && !start_seen;
        cnt_clr  = bus.frame_start && !start_seen;
      end
      default: ;
    endcase
  end

  assign res = seg_to_digit(seg_on);

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_r <= '0;
      mask_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      mcnt    <= '0;
    end else begin
      valid_r <= dec_en;
      if (dec_en) begin
        mask_r  <= seg_on;
        digit_r <= res.digit;
        err_r   <= res.err;
        if (res.err) mcnt <= '0;
        else if (res.digit == digit_r && mcnt != '0) begin
          if (mcnt != MC_SAT) mcnt <= mcnt + 1'b1;
        end else mcnt <= MC_W'(1);
      end else if (abort) begin
        mcnt <= '0;
      end
    end
  end

  assign bus.digit       = digit_r;
  assign bus.seg_mask    = mask_r;
  assign bus.digit_valid = valid_r;
  assign bus.glyph_err   = err_r;
  assign bus.stable      = (mcnt >= MC_SAT);

endmodule

// File: tb/tb_read_num_com_mass.sv
// Scoreboard bench: renders 7-segment frames over a cropped raster, queues expected
// decodes at frame_end and compares them against every digit_valid pulse.
module tb_read_num_com_mass;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  read_num_com_mass_if bus();
  read_num_com_mass dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0] digit;
    logic [6:0] mask;
    logic       err;
    logic       stable;
    int         vcyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         lat = 1;
  logic [7:0] hist = '0;
  int         m_cnt = 0;
  logic [3:0] m_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h14;  2: return 7'h6E;  3: return 7'h76;
      4: return 7'h55;  5: return 7'h73;  6: return 7'h7B;  7: return 7'h16;
      8: return 7'h7F;  9: return 7'h77;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic inbox(input int dx, dy, x0, x1, y0, y1);
    return dx >= x0 && dx <= x1 && dy >= y0 && dy <= y1;
  endfunction

  function automatic logic lit(input logic [6:0] m, input int dx, input int dy);
    return (m[0] && inbox(dx, dy, 0, 3, 0, 23))   || (m[1] && inbox(dx, dy, 0, 13, 0, 3))  ||
           (m[2] && inbox(dx, dy, 10, 13, 0, 23)) || (m[3] && inbox(dx, dy, 0, 3, 20, 43)) ||
           (m[4] && inbox(dx, dy, 10, 13, 20, 43))|| (m[5] && inbox(dx, dy, 0, 13, 40, 43))||
           (m[6] && inbox(dx, dy, 0, 13, 20, 23));
  endfunction

  // Renderer model: pix_in shows the pixel of the coordinate driven 'lat' cycles ago.
  task automatic drive(input int cx, input int cy, input logic fs, input logic fe, input logic [6:0] m);
    bus.countx      = 11'(cx);
    bus.county      = 10'(cy);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    hist            = {hist[6:0], lit(m, cx - 100, cy - 50)};
    bus.pix_in      = hist[lat];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 7'h00);
  endtask

  task automatic expect_dec(input logic [6:0] em);
    exp_t e;
    int   d;
    d = -1;
    for (int i = 0; i < 10; i++) if (glyph(i) == em) d = i;
    e.mask  = em;
    e.err   = (d < 0);
    e.digit = (d < 0) ? 4'd0 : 4'(d);
    if (e.err) m_cnt = 0;
    else if (e.digit == m_prev && m_cnt > 0) m_cnt++;
    else m_cnt = 1;
    m_prev   = e.digit;
    e.stable = (m_cnt >= 3);
    e.vcyc   = cyc + 2;
    sb.push_back(e);
  endtask

  // Cropped raster x 96..119, y 46..95 covers the digit at (100,50).
  task automatic run_frame(input logic [6:0] rm, input logic [6:0] em,
                           input bit first_fs, input bit last_fs, input int abort_n);
    int n;
    n = 0;
    for (int yy = 46; yy <= 95; yy++) begin
      for (int xx = 96; xx <= 119; xx++) begin
        bit last;
        last = (yy == 95 && xx == 119);
        if (abort_n > 0 && n == abort_n) begin
          m_cnt = 0;
          return;
        end
        if (last) expect_dec(em);
        drive(xx, yy, (first_fs && n == 0) || (last && last_fs), last, rm);
        n++;
      end
    end
  endtask

  task automatic chk_zero();
    @(negedge clk);
    chk("rst_digit", bus.digit, 0);
    chk("rst_seg_mask", bus.seg_mask, 0);
    chk("rst_valid", bus.digit_valid, 0);
    chk("rst_glyph_err", bus.glyph_err, 0);
    chk("rst_stable", bus.stable, 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.digit_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("digit", bus.digit, e.digit);
        chk("seg_mask", bus.seg_mask, e.mask);
        chk("glyph_err", bus.glyph_err, e.err);
        chk("stable", bus.stable, e.stable);
        chk("valid_cycle", cyc, e.vcyc);
      end
    end
  end

  initial begin
    bus.x = 11'd100;
    bus.y = 10'd50;
    bus.countx = '0;
    bus.county = '0;
    bus.pix_in = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero();
    reset = 1'b1;
    idle(3);

    for (int d = 0; d < 10; d++) begin
      run_frame(glyph(d), glyph(d), 1, 0, 0);
      idle(4);
    end
    run_frame(glyph(12), 7'h7F, 1, 0, 0);
    idle(4);
    run_frame(7'h02, 7'h02, 1, 0, 0);
    idle(4);

    // Aborted frame, then a complete one.
    run_frame(glyph(3), glyph(3), 1, 0, 300);
    run_frame(glyph(3), glyph(3), 1, 0, 0);
    idle(4);

    // Stability: back-to-back 5s, the last ending together with the next start.
    run_frame(glyph(5), glyph(5), 1, 0, 0);
    run_frame(glyph(5), glyph(5), 1, 0, 0);
    run_frame(glyph(5), glyph(5), 1, 1, 0);
    run_frame(glyph(6), glyph(6), 0, 0, 0);
    idle(4);

    // Reset in the middle of accumulation.
    run_frame(glyph(7), glyph(7), 1, 0, 500);
    reset = 1'b0;
    idle(2);
    chk_zero();
    reset = 1'b1;
    m_cnt = 0;
    m_prev = '0;
    idle(3);
    run_frame(glyph(7), glyph(7), 1, 0, 0);
    idle(4);

    // One pixel of extra renderer latency keeps every probe at 4 hits.
    lat = 2;
    idle(4);
    run_frame(glyph(2), glyph(2), 1, 0, 0);
    idle(4);
    // Two pixels drop the left/right vertical probes to 2 hits: only top, bottom, mid remain.
    lat = 3;
    idle(4);
    run_frame(glyph(8), 7'h62, 1, 0, 0);
    idle(10);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
